// File: rtl/ex_alu_rs_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ex_alu_rs_pkg                                                |
// | Description : Shared opcode encodings, tag/register constants and the      |
// |               branch-op helper for the buffered integer execute stage.     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package ex_alu_rs_pkg;

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_XOR   = 5'd2;
    localparam logic [4:0] OP_OR    = 5'd3;
    localparam logic [4:0] OP_AND   = 5'd4;
    localparam logic [4:0] OP_SLL   = 5'd5;
    localparam logic [4:0] OP_SRL   = 5'd6;
    localparam logic [4:0] OP_SRA   = 5'd7;
    localparam logic [4:0] OP_SLT   = 5'd8;
    localparam logic [4:0] OP_SLTU  = 5'd9;
    localparam logic [4:0] OP_LUI   = 5'd10;
    localparam logic [4:0] OP_AUIPC = 5'd11;
    localparam logic [4:0] OP_JAL   = 5'd12;
    localparam logic [4:0] OP_JALR  = 5'd13;
    localparam logic [4:0] OP_BEQ   = 5'd16;
    localparam logic [4:0] OP_BNE   = 5'd17;
    localparam logic [4:0] OP_BLT   = 5'd18;
    localparam logic [4:0] OP_BGE   = 5'd19;
    localparam logic [4:0] OP_BLTU  = 5'd20;
    localparam logic [4:0] OP_BGEU  = 5'd21;

    // Rename tag meaning "operand already present".
    localparam int unsigned UNLOCKED = 0;
    // Architectural register x0; branches write nothing.
    localparam logic [4:0] ZERO = 5'd0;

    function automatic logic op_is_branch(input logic [4:0] op);
        return (op == OP_BEQ)  || (op == OP_BNE)  || (op == OP_BLT) ||
               (op == OP_BGE)  || (op == OP_BLTU) || (op == OP_BGEU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_alu_rs_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ex_alu_rs_if                                                 |
// | Description : Issue, wakeup and result bundle of the execute stage.        |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
interface ex_alu_rs_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4,
    parameter int OP_W  = 5
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic             rdy;
    logic             flush;
    logic             issue_valid;
    logic             issue_ready;
    logic [OP_W-1:0]  issue_op;
    logic [XLEN-1:0]  issue_pc;
    logic [XLEN-1:0]  issue_imm;
    logic [XLEN-1:0]  issue_datax;
    logic [XLEN-1:0]  issue_datay;
    logic [TAG_W-1:0] issue_tagx;
    logic [TAG_W-1:0] issue_tagy;
    logic [TAG_W-1:0] issue_dest_tag;
    logic [4:0]       issue_target;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [XLEN-1:0]  cdb_data;
    logic             res_valid;
    logic             res_ready;
    logic [TAG_W-1:0] res_tag;
    logic [4:0]       res_target;
    logic [XLEN-1:0]  res_data;
    logic             jmp_en;
    logic [XLEN-1:0]  jmp_addr;
    logic [OCC_W-1:0] occupancy;

    modport master (
        output rdy, flush, issue_valid, issue_op, issue_pc, issue_imm,
               issue_datax, issue_datay, issue_tagx, issue_tagy,
               issue_dest_tag, issue_target, cdb_valid, cdb_tag, cdb_data,
               res_ready,
        input  issue_ready, res_valid, res_tag, res_target, res_data,
               jmp_en, jmp_addr, occupancy
    );

    modport slave (
        input  rdy, flush, issue_valid, issue_op, issue_pc, issue_imm,
               issue_datax, issue_datay, issue_tagx, issue_tagy,
               issue_dest_tag, issue_target, cdb_valid, cdb_tag, cdb_data,
               res_ready,
        output issue_ready, res_valid, res_tag, res_target, res_data,
               jmp_en, jmp_addr, occupancy
    );
endinterface
`default_nettype wire

// File: rtl/ex_alu_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ex_alu_core                                                  |
// | Description : Combinational integer ALU with jump/branch redirect.         |
// |               Optional: EX_ALU_BRANCH_EN adds BEQ/BNE/BLT/BGE/BLTU/BGEU.   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module ex_alu_core
    import ex_alu_rs_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OP_W = 5
) (
    input  wire logic [OP_W-1:0] i_op,
    input  wire logic [XLEN-1:0] i_pc,
    input  wire logic [XLEN-1:0] i_imm,
    input  wire logic [XLEN-1:0] i_datax,
    input  wire logic [XLEN-1:0] i_datay,
    output logic      [XLEN-1:0] o_data,
    output logic                 o_jmp_en,
    output logic      [XLEN-1:0] o_jmp_addr
);
    localparam int SH_W = $clog2(XLEN);

    logic [SH_W-1:0] w_shamt;
    logic [XLEN-1:0] w_pc_4;
    logic [XLEN-1:0] w_pc_imm;
    logic [XLEN-1:0] w_jalr_sum;

    assign w_shamt    = i_datay[SH_W-1:0];
    assign w_pc_4     = i_pc + XLEN'(4);
    assign w_pc_imm   = i_pc + i_imm;
    assign w_jalr_sum = i_datax + i_imm;

`ifdef EX_ALU_BRANCH_EN
    logic w_taken;

    always_comb begin
        w_taken = 1'b0;
        case (i_op)
            OP_BEQ:  w_taken = (i_datax == i_datay);
            OP_BNE:  w_taken = (i_datax != i_datay);
            OP_BLT:  w_taken = ($signed(i_datax) <  $signed(i_datay));
            OP_BGE:  w_taken = ($signed(i_datax) >= $signed(i_datay));
            OP_BLTU: w_taken = (i_datax <  i_datay);
            OP_BGEU: w_taken = (i_datax >= i_datay);
            default: w_taken = 1'b0;
        endcase
    end
`endif

    always_comb begin
        o_data     = '0;
        o_jmp_en   = 1'b0;
        o_jmp_addr = '0;
        case (i_op)
            OP_ADD:   o_data = i_datax + i_datay;
            OP_SUB:   o_data = i_datax - i_datay;
            OP_XOR:   o_data = i_datax ^ i_datay;
            OP_OR:    o_data = i_datax | i_datay;
            OP_AND:   o_data = i_datax & i_datay;
            OP_SLL:   o_data = i_datax << w_shamt;
            OP_SRL:   o_data = i_datax >> w_shamt;
            OP_SRA:   o_data = $unsigned($signed(i_datax) >>> w_shamt);
            OP_SLT:   o_data = XLEN'($signed(i_datax) < $signed(i_datay));
            OP_SLTU:  o_data = XLEN'(i_datax < i_datay);
            OP_LUI:   o_data = i_datax;
            OP_AUIPC: o_data = i_pc + i_datax;
            OP_JAL: begin
                o_data     = w_pc_4;
                o_jmp_en   = 1'b1;
                o_jmp_addr = w_pc_imm;
            end
            OP_JALR: begin
                o_data     = w_pc_4;
                o_jmp_en   = 1'b1;
                o_jmp_addr = {w_jalr_sum[XLEN-1:1], 1'b0};
            end
`ifdef EX_ALU_BRANCH_EN
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                o_jmp_en   = 1'b1;
                o_jmp_addr = w_taken ? w_pc_imm : w_pc_4;
            end
`endif
            default: begin
                o_data     = '0;
                o_jmp_en   = 1'b0;
                o_jmp_addr = '0;
            end
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/ex_alu_rs.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ex_alu_rs                                                    |
// | Description : DEPTH-entry operand-wait buffer with CDB wakeup in front of  |
// |               an XLEN ALU; registered valid/ready result port.             |
// |               Optional: EX_ALU_BRANCH_EN enables conditional branches.     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module ex_alu_rs
    import ex_alu_rs_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4,
    parameter int OP_W  = 5
) (
    input  wire logic   clk,
    input  wire logic   rst,
    ex_alu_rs_if.slave  bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic             valid;
        logic [OP_W-1:0]  op;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  datax;
        logic [XLEN-1:0]  datay;
        logic [TAG_W-1:0] tagx;
        logic [TAG_W-1:0] tagy;
        logic [TAG_W-1:0] dest_tag;
        logic [4:0]       target;
    } rs_entry_t;

    rs_entry_t        r_ent [DEPTH];
    logic             r_res_valid;
    logic [TAG_W-1:0] r_res_tag;
    logic [4:0]       r_res_target;
    logic [XLEN-1:0]  r_res_data;
    logic             r_jmp_en;
    logic [XLEN-1:0]  r_jmp_addr;

    logic [DEPTH-1:0] w_ready;
    logic             w_free_found;
    logic [IDX_W-1:0] w_free_idx;
    logic             w_sel_found;
    logic [IDX_W-1:0] w_sel_idx;
    logic [OCC_W-1:0] w_occ;
    logic             w_wake;
    logic             w_issue_ready;
    logic             w_issue_fire;
    logic             w_sel_fire;
    rs_entry_t        w_new;
    logic [XLEN-1:0]  w_alu_data;
    logic             w_alu_jmp_en;
    logic [XLEN-1:0]  w_alu_jmp_addr;
    logic [4:0]       w_res_target;

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_ready
            assign w_ready[g] = r_ent[g].valid &&
                                (r_ent[g].tagx == TAG_W'(UNLOCKED)) &&
                                (r_ent[g].tagy == TAG_W'(UNLOCKED));
        end
    endgenerate

    // Descending scans leave the lowest matching index in place.
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_sel_found  = 1'b0;
        w_sel_idx    = '0;
        w_occ        = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_ent[i].valid) begin
                w_free_found = 1'b1;
                w_free_idx   = IDX_W'(i);
            end
            if (w_ready[i]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = IDX_W'(i);
            end
            w_occ = w_occ + OCC_W'(r_ent[i].valid);
        end
    end

    assign w_wake        = bus.rdy && bus.cdb_valid && (bus.cdb_tag != TAG_W'(UNLOCKED));
    assign w_issue_ready = bus.rdy && !bus.flush && w_free_found;
    assign w_issue_fire  = w_issue_ready && bus.issue_valid;
    assign w_sel_fire    = bus.rdy && !bus.flush && w_sel_found &&
                           (!r_res_valid || bus.res_ready);

    // A broadcast in the issue cycle is captured directly into the new entry.
    always_comb begin
        w_new          = '0;
        w_new.valid    = 1'b1;
        w_new.op       = bus.issue_op;
        w_new.pc       = bus.issue_pc;
        w_new.imm      = bus.issue_imm;
        w_new.datax    = bus.issue_datax;
        w_new.datay    = bus.issue_datay;
        w_new.tagx     = bus.issue_tagx;
        w_new.tagy     = bus.issue_tagy;
        w_new.dest_tag = bus.issue_dest_tag;
        w_new.target   = bus.issue_target;
        if (w_wake && (bus.issue_tagx == bus.cdb_tag)) begin
            w_new.datax = bus.cdb_data;
            w_new.tagx  = TAG_W'(UNLOCKED);
        end
        if (w_wake && (bus.issue_tagy == bus.cdb_tag)) begin
            w_new.datay = bus.cdb_data;
            w_new.tagy  = TAG_W'(UNLOCKED);
        end
    end

    ex_alu_core #(
        .XLEN (XLEN),
        .OP_W (OP_W)
    ) u_core (
        .i_op       (r_ent[w_sel_idx].op),
        .i_pc       (r_ent[w_sel_idx].pc),
        .i_imm      (r_ent[w_sel_idx].imm),
        .i_datax    (r_ent[w_sel_idx].datax),
        .i_datay    (r_ent[w_sel_idx].datay),
        .o_data     (w_alu_data),
        .o_jmp_en   (w_alu_jmp_en),
        .o_jmp_addr (w_alu_jmp_addr)
    );

`ifdef EX_ALU_BRANCH_EN
    assign w_res_target = op_is_branch(5'(r_ent[w_sel_idx].op)) ? ZERO
                                                                : r_ent[w_sel_idx].target;
`else
    assign w_res_target = r_ent[w_sel_idx].target;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i] <= '0;
            end
            r_res_valid  <= 1'b0;
            r_res_tag    <= '0;
            r_res_target <= '0;
            r_res_data   <= '0;
            r_jmp_en     <= 1'b0;
            r_jmp_addr   <= '0;
        end else if (bus.rdy) begin
            if (bus.flush) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_ent[i].valid <= 1'b0;
                end
                r_res_valid <= 1'b0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (r_ent[i].valid && w_wake) begin
                        if (r_ent[i].tagx == bus.cdb_tag) begin
                            r_ent[i].datax <= bus.cdb_data;
                            r_ent[i].tagx  <= TAG_W'(UNLOCKED);
                        end
                        if (r_ent[i].tagy == bus.cdb_tag) begin
                            r_ent[i].datay <= bus.cdb_data;
                            r_ent[i].tagy  <= TAG_W'(UNLOCKED);
                        end
                    end
                end
                if (w_sel_fire) begin
                    r_ent[w_sel_idx].valid <= 1'b0;
                    r_res_valid  <= 1'b1;
                    r_res_tag    <= r_ent[w_sel_idx].dest_tag;
                    r_res_target <= w_res_target;
                    r_res_data   <= w_alu_data;
                    r_jmp_en     <= w_alu_jmp_en;
                    r_jmp_addr   <= w_alu_jmp_addr;
                end else if (bus.res_ready) begin
                    r_res_valid <= 1'b0;
                end
                // The free slot is invalid, so it never collides with the selected one.
                if (w_issue_fire) begin
                    r_ent[w_free_idx] <= w_new;
                end
            end
        end
    end

    assign bus.issue_ready = w_issue_ready;
    assign bus.res_valid   = r_res_valid;
    assign bus.res_tag     = r_res_tag;
    assign bus.res_target  = r_res_target;
    assign bus.res_data    = r_res_data;
    assign bus.jmp_en      = r_jmp_en;
    assign bus.jmp_addr    = r_jmp_addr;
    assign bus.occupancy   = w_occ;
endmodule
`default_nettype wire

// File: tb/tb_ex_alu_rs.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ex_alu_rs                                                 |
// | Description : Directed scoreboard bench for ex_alu_rs (XLEN 32, DEPTH 4).  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_ex_alu_rs;
    import ex_alu_rs_pkg::*;

    logic clk;
    logic rst;

    ex_alu_rs_if #(.XLEN(32), .DEPTH(4), .TAG_W(4), .OP_W(5)) bus ();

    ex_alu_rs #(.XLEN(32), .DEPTH(4), .TAG_W(4), .OP_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  tag;
        logic [4:0]  tgt;
        logic [31:0] data;
        logic        jmp;
        logic [31:0] addr;
    } exp_t;

    exp_t q[$];
    int n_pass   = 0;
    int n_fail   = 0;
    int n_checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] tag, input logic [4:0] tgt, input logic [31:0] data,
                        input logic jmp, input logic [31:0] addr);
        exp_t e;
        e.tag = tag; e.tgt = tgt; e.data = data; e.jmp = jmp; e.addr = addr;
        q.push_back(e);
    endtask

    task automatic check_res();
        exp_t e;
        chk("res_valid", 64'(bus.res_valid), 64'd1);
        chk("sb_pending", 64'(q.size() > 0), 64'd1);
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("res_tag",    64'(bus.res_tag),    64'(e.tag));
            chk("res_target", 64'(bus.res_target), 64'(e.tgt));
            chk("res_data",   64'(bus.res_data),   64'(e.data));
            chk("jmp_en",     64'(bus.jmp_en),     64'(e.jmp));
            chk("jmp_addr",   64'(bus.jmp_addr),   64'(e.addr));
        end
    endtask

    // Outputs being drained in the upcoming edge are checked before it.
    task automatic issue(input logic [4:0] op, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] x, input logic [31:0] y,
                         input logic [3:0] tx, input logic [3:0] ty,
                         input logic [3:0] dt, input logic [4:0] tg);
        if (bus.res_valid === 1'b1 && bus.res_ready === 1'b1) check_res();
        bus.issue_op = op; bus.issue_pc = pc; bus.issue_imm = imm;
        bus.issue_datax = x; bus.issue_datay = y;
        bus.issue_tagx = tx; bus.issue_tagy = ty;
        bus.issue_dest_tag = dt; bus.issue_target = tg;
        bus.issue_valid = 1'b1;
        #1;
        chk("issue_ready", 64'(bus.issue_ready), 64'd1);
        step();
        bus.issue_valid = 1'b0;
    endtask

    task automatic cdb_bcast(input logic [3:0] tag, input logic [31:0] data);
        bus.cdb_valid = 1'b1; bus.cdb_tag = tag; bus.cdb_data = data;
        step();
        bus.cdb_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int c = 0; c < budget && q.size() > 0; c++) begin
            if (bus.res_valid === 1'b1) check_res();
            step();
        end
        chk("sb_drained", 64'(q.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus.rdy = 1'b1; bus.flush = 1'b0; bus.issue_valid = 1'b0;
        bus.issue_op = '0; bus.issue_pc = '0; bus.issue_imm = '0;
        bus.issue_datax = '0; bus.issue_datay = '0;
        bus.issue_tagx = '0; bus.issue_tagy = '0;
        bus.issue_dest_tag = '0; bus.issue_target = '0;
        bus.cdb_valid = 1'b0; bus.cdb_tag = '0; bus.cdb_data = '0;
        bus.res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
        chk("rst_res_data",  64'(bus.res_data),  64'd0);
        chk("rst_jmp_en",    64'(bus.jmp_en),    64'd0);
        chk("rst_jmp_addr",  64'(bus.jmp_addr),  64'd0);
        chk("rst_occ",       64'(bus.occupancy), 64'd0);
        chk("rst_issue_rdy", 64'(bus.issue_ready), 64'd1);

        // ADD with both operands present
        push(4'd5, 5'd3, 32'd12, 1'b0, 32'd0);
        issue(OP_ADD, 32'h0, 32'h0, 32'd5, 32'd7, 4'd0, 4'd0, 4'd5, 5'd3);
        chk("add_occ_1",   64'(bus.occupancy), 64'd1);
        chk("add_pending", 64'(bus.res_valid), 64'd0);
        step();
        check_res();
        chk("add_occ_0", 64'(bus.occupancy), 64'd0);
        step();
        chk("add_drained", 64'(bus.res_valid), 64'd0);

        // SUB waiting on tag 3; tag 2 must not wake it
        push(4'd6, 5'd4, 32'd12, 1'b0, 32'd0);
        issue(OP_SUB, 32'h0, 32'h0, 32'd0, 32'd8, 4'd3, 4'd0, 4'd6, 5'd4);
        cdb_bcast(4'd2, 32'd99);
        step();
        chk("tag2_no_result", 64'(bus.res_valid), 64'd0);
        chk("tag2_occ",       64'(bus.occupancy), 64'd1);
        cdb_bcast(4'd3, 32'd20);
        chk("wake_not_yet", 64'(bus.res_valid), 64'd0);
        step();
        check_res();
        step();

        // Bypass: operand tag matches the broadcast in the issue cycle
        push(4'd3, 5'd9, 32'd42, 1'b0, 32'd0);
        bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd7; bus.cdb_data = 32'd50;
        issue(OP_SUB, 32'h0, 32'h0, 32'd0, 32'd8, 4'd7, 4'd0, 4'd3, 5'd9);
        bus.cdb_valid = 1'b0;
        step();
        check_res();
        step();

        // Fill the buffer with stalled output
        bus.res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(4'(8 + i), 5'(i + 1), 32'(100 + i), 1'b0, 32'd0);
            issue(OP_ADD, 32'h0, 32'h0, 32'd0, 32'(i), 4'd1, 4'd0, 4'(8 + i), 5'(i + 1));
        end
        chk("full_issue_rdy", 64'(bus.issue_ready), 64'd0);
        chk("full_occ",       64'(bus.occupancy),   64'd4);
        cdb_bcast(4'd1, 32'd100);
        chk("sel_cycle_full", 64'(bus.issue_ready), 64'd0);
        chk("sel_cycle_occ",  64'(bus.occupancy),   64'd4);
        step();
        chk("first_out_valid", 64'(bus.res_valid),   64'd1);
        chk("first_out_data",  64'(bus.res_data),    64'd100);
        chk("slot_freed",      64'(bus.issue_ready), 64'd1);
        chk("stall_occ",       64'(bus.occupancy),   64'd3);
        step();
        chk("held_valid", 64'(bus.res_valid), 64'd1);
        chk("held_data",  64'(bus.res_data),  64'd100);
        chk("held_tag",   64'(bus.res_tag),   64'd8);
        chk("held_occ",   64'(bus.occupancy), 64'd3);
        bus.res_ready = 1'b1;
        drain(20);
        chk("fill_empty", 64'(bus.occupancy), 64'd0);

        // Op coverage, back to back
        push(4'd1, 5'd1, 32'h104, 1'b1, 32'h206);
        issue(OP_JALR, 32'h100, 32'h4, 32'h203, 32'h0, 4'd0, 4'd0, 4'd1, 5'd1);
        push(4'd2, 5'd2, 32'h204, 1'b1, 32'h220);
        issue(OP_JAL, 32'h200, 32'h20, 32'h0, 32'h0, 4'd0, 4'd0, 4'd2, 5'd2);
        push(4'd3, 5'd3, 32'hC000_0000, 1'b0, 32'd0);
        issue(OP_SRA, 32'h0, 32'h0, 32'h8000_0000, 32'd33, 4'd0, 4'd0, 4'd3, 5'd3);
        push(4'd4, 5'd4, 32'd0, 1'b0, 32'd0);
        issue(OP_SLTU, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'd1, 4'd0, 4'd0, 4'd4, 5'd4);
        push(4'd5, 5'd5, 32'd1, 1'b0, 32'd0);
        issue(OP_SLT, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'd1, 4'd0, 4'd0, 4'd5, 5'd5);
        push(4'd6, 5'd6, 32'h8000_0000, 1'b0, 32'd0);
        issue(OP_SLL, 32'h0, 32'h0, 32'd1, 32'd31, 4'd0, 4'd0, 4'd6, 5'd6);
        push(4'd7, 5'd7, 32'h0800_0000, 1'b0, 32'd0);
        issue(OP_SRL, 32'h0, 32'h0, 32'h8000_0000, 32'd4, 4'd0, 4'd0, 4'd7, 5'd7);
        push(4'd8, 5'd8, 32'hFF00, 1'b0, 32'd0);
        issue(OP_XOR, 32'h0, 32'h0, 32'hF0F0, 32'h0FF0, 4'd0, 4'd0, 4'd8, 5'd8);
        push(4'd9, 5'd9, 32'hFFF0, 1'b0, 32'd0);
        issue(OP_OR, 32'h0, 32'h0, 32'hF0F0, 32'h0FF0, 4'd0, 4'd0, 4'd9, 5'd9);
        push(4'd10, 5'd10, 32'h00F0, 1'b0, 32'd0);
        issue(OP_AND, 32'h0, 32'h0, 32'hF0F0, 32'h0FF0, 4'd0, 4'd0, 4'd10, 5'd10);
        push(4'd11, 5'd11, 32'h1234_5000, 1'b0, 32'd0);
        issue(OP_LUI, 32'h0, 32'h0, 32'h1234_5000, 32'h0, 4'd0, 4'd0, 4'd11, 5'd11);
        push(4'd12, 5'd12, 32'h3000, 1'b0, 32'd0);
        issue(OP_AUIPC, 32'h1000, 32'h0, 32'h2000, 32'h0, 4'd0, 4'd0, 4'd12, 5'd12);
        push(4'd13, 5'd13, 32'd1, 1'b0, 32'd0);
        issue(OP_ADD, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'd2, 4'd0, 4'd0, 4'd13, 5'd13);
        push(4'd14, 5'd14, 32'hFFFF_FFFF, 1'b0, 32'd0);
        issue(OP_SUB, 32'h0, 32'h0, 32'd0, 32'd1, 4'd0, 4'd0, 4'd14, 5'd14);
        push(4'd15, 5'd15, 32'd0, 1'b0, 32'd0);
        issue(5'd31, 32'h40, 32'h10, 32'h55, 32'h66, 4'd0, 4'd0, 4'd15, 5'd15);
`ifdef EX_ALU_BRANCH_EN
        push(4'd2, 5'd0, 32'd0, 1'b1, 32'h50);
`else
        push(4'd2, 5'd7, 32'd0, 1'b0, 32'd0);
`endif
        issue(OP_BLT, 32'h40, 32'h10, 32'hFFFF_FFFF, 32'd1, 4'd0, 4'd0, 4'd2, 5'd7);
        drain(20);

        // Flush beats a pending result, a waiting entry and a same-cycle issue
        bus.res_ready = 1'b0;
        issue(OP_ADD, 32'h0, 32'h0, 32'd1, 32'd1, 4'd0, 4'd0, 4'd1, 5'd1);
        issue(OP_ADD, 32'h0, 32'h0, 32'd1, 32'd1, 4'd9, 4'd0, 4'd2, 5'd2);
        chk("pre_flush_valid", 64'(bus.res_valid), 64'd1);
        chk("pre_flush_occ",   64'(bus.occupancy), 64'd1);
        bus.flush = 1'b1;
        bus.issue_valid = 1'b1;
        #1;
        chk("flush_issue_rdy", 64'(bus.issue_ready), 64'd0);
        step();
        bus.flush = 1'b0;
        bus.issue_valid = 1'b0;
        chk("flush_res_valid", 64'(bus.res_valid), 64'd0);
        chk("flush_occ",       64'(bus.occupancy), 64'd0);
        bus.res_ready = 1'b1;

        // rdy low freezes state, including wakeup
        push(4'd12, 5'd13, 32'd43, 1'b0, 32'd0);
        issue(OP_ADD, 32'h0, 32'h0, 32'd0, 32'd3, 4'd5, 4'd0, 4'd12, 5'd13);
        bus.rdy = 1'b0;
        #1;
        chk("rdy_low_issue_rdy", 64'(bus.issue_ready), 64'd0);
        cdb_bcast(4'd5, 32'd40);
        bus.rdy = 1'b1;
        step();
        chk("rdy_low_no_wake", 64'(bus.res_valid), 64'd0);
        chk("rdy_low_occ",     64'(bus.occupancy), 64'd1);
        cdb_bcast(4'd5, 32'd40);
        drain(10);

        // Reset mid-operation, with rdy low
        issue(OP_ADD, 32'h0, 32'h0, 32'd0, 32'd0, 4'd6, 4'd0, 4'd1, 5'd1);
        bus.rdy = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.rdy = 1'b1;
        chk("mid_rst_occ",   64'(bus.occupancy), 64'd0);
        chk("mid_rst_valid", 64'(bus.res_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
